// File: rtl/avg_pkg.sv
// Shared types and helpers for the round-robin AVG scheduler.
package avg_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arb
    import avg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    int             idx;
    logic [IDW-1:0] idx_b;

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        idx_b   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx   = (int'(ptr) + i) % NREQ;
            idx_b = IDW'(idx);
            if (req[idx_b]) begin
                gnt        = '0;
                gnt[idx_b] = 1'b1;
                gnt_idx    = idx_b;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/avg_rr_sched.sv
// Shares one AVG datapath between NREQ requesters, one WIN-sample window per grant,
// and returns the tagged average (or a timeout marker) on a valid/ready port.
module avg_rr_sched
    import avg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WIN  = 4,
    parameter int TMO  = 16,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   avg_active,
    output logic [DATA_W-1:0]      avg_data_in,
    input  logic                   avg_done,
    input  logic [DATA_W-1:0]      avg_data_out,
    output logic                   res_valid,
    output logic [DATA_W-1:0]      res_data,
    output logic [IDW-1:0]         res_id,
    output logic                   res_tmo,
    input  logic                   res_ready,
    output logic                   busy
);

    localparam logic [7:0] WIN_LAST = 8'(WIN - 1);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t            state, state_nxt;
    logic [IDW-1:0]    sel, rr_ptr, gnt_idx;
    logic [NREQ-1:0]   sel_oh, gnt;
    logic              any;
    logic [7:0]        cnt, timer;
    logic              xfer, last_xfer, tmo_hit;
    logic [DATA_W-1:0] sel_data;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign sel_data  = req_data[int'(sel)*DATA_W +: DATA_W];
    assign xfer      = (state == FEED) && req_valid[sel];
    assign last_xfer = xfer && (cnt == WIN_LAST);
    assign tmo_hit   = (timer == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any) state_nxt = FEED;
            FEED:    if (last_xfer) state_nxt = WAIT;
            WAIT:    if (avg_done || tmo_hit) state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A bubble in FEED is a nop to AVG: active and data both forced low.
    always_comb begin
        req_ready   = '0;
        avg_active  = 1'b0;
        avg_data_in = '0;
        res_valid   = 1'b0;
        busy        = (state != IDLE);
        case (state)
            FEED: begin
                req_ready   = sel_oh;
                avg_active  = xfer;
                avg_data_in = xfer ? sel_data : '0;
            end
            RESP:    res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            sel_oh   <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            timer    <= '0;
            res_data <= '0;
            res_id   <= '0;
            res_tmo  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    sel    <= gnt_idx;
                    sel_oh <= gnt;
                    cnt    <= '0;
                end
                FEED: if (xfer) begin
                    cnt <= cnt + 8'd1;
                    if (last_xfer) timer <= '0;
                end
                // done takes priority over a coincident timeout
                WAIT: begin
                    if (avg_done) begin
                        res_data <= avg_data_out;
                        res_id   <= sel;
                        res_tmo  <= 1'b0;
                    end else if (tmo_hit) begin
                        res_data <= '0;
                        res_id   <= sel;
                        res_tmo  <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: if (res_ready) rr_ptr <= (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_rr_sched.sv
// Directed bench for avg_rr_sched with an AVG model and a result scoreboard.
module tb_avg_rr_sched;

    localparam int NREQ = 4;
    localparam int WIN  = 4;
    localparam int TMO  = 16;
    localparam int IDW  = 2;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [8*NREQ-1:0]    req_data;
    logic                 avg_active, avg_done, res_valid, res_tmo, res_ready, busy;
    logic [7:0]           avg_data_in, avg_data_out, res_data;
    logic [IDW-1:0]       res_id;
    logic                 mdl_done = 1'b0, man_done = 1'b0;
    logic [7:0]           mdl_data = 8'h00, man_data = 8'h00;

    assign avg_done     = mdl_done | man_done;
    assign avg_data_out = man_done ? man_data : mdl_data;

    avg_rr_sched #(.NREQ(NREQ), .WIN(WIN), .TMO(TMO), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .avg_active   (avg_active),
        .avg_data_in  (avg_data_in),
        .avg_done     (avg_done),
        .avg_data_out (avg_data_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_id       (res_id),
        .res_tmo      (res_tmo),
        .res_ready    (res_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]     d;
        logic [IDW-1:0] id;
        logic           tmo;
    } res_t;

    res_t expq[$];
    int   vec = 0, errs = 0, nres = 0, cyc = 0, hs_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AVG model: averages each WIN-sample window, reports done two cycles later.
    int mcnt = 0, msum = 0, mpend = 0, mavg = 0;
    bit model_en = 1'b1;
    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt = 0; msum = 0; mpend = 0;
            mdl_done <= 1'b0;
            mdl_data <= 8'h00;
        end else begin
            mdl_done <= 1'b0;
            if (mpend == 1 && model_en) begin
                mdl_done <= 1'b1;
                mdl_data <= 8'(mavg);
            end
            if (mpend > 0) mpend--;
            if (avg_active) begin
                msum += int'($signed(avg_data_in));
                mcnt++;
                if (mcnt == WIN) begin
                    mavg = msum / WIN; msum = 0; mcnt = 0; mpend = 2;
                end
            end
        end
    end

    // Result monitor: stability while stalled, scoreboard pop on handshake.
    logic [7:0]     sd;
    logic [IDW-1:0] si;
    logic           st;
    bit             hv = 1'b0;
    always @(posedge clk) begin
        #4;
        if (!rst_n) hv = 1'b0;
        else if (res_valid) begin
            if (hv) chk("res_stable", 32'({res_data, res_id, res_tmo}), 32'({sd, si, st}));
            sd = res_data; si = res_id; st = res_tmo;
            if (res_ready) begin
                if (expq.size() == 0) chk("res_unexpected", 32'(res_valid), 0);
                else begin
                    res_t e;
                    e = expq.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.d));
                    chk("res_id",   32'(res_id),   32'(e.id));
                    chk("res_tmo",  32'(res_tmo),  32'(e.tmo));
                end
                nres++;
                hs_cyc = cyc;
                hv = 1'b0;
            end else hv = 1'b1;
        end else hv = 1'b0;
    end

    int quota[NREQ], dbase[NREQ], dstep[NREQ], bub_at[NREQ], bub_len[NREQ];
    int hold = 0;
    bit stray = 1'b0, coin = 1'b0;
    int act_n, act_first, act_last, wait_start, rv_cyc;
    int glog[$];

    function automatic logic [7:0] samp(input int k, input int j);
        return 8'(dbase[k] + dstep[k] * (j % WIN));
    endfunction

    task automatic clr();
        for (int k = 0; k < NREQ; k++) begin
            quota[k] = 0; dbase[k] = 0; dstep[k] = 0; bub_at[k] = 0; bub_len[k] = 0;
        end
        hold = 0; stray = 1'b0; coin = 1'b0;
    endtask

    task automatic chk_zero();
        chk("rst_req_ready",   32'(req_ready),   0);
        chk("rst_avg_active",  32'(avg_active),  0);
        chk("rst_avg_data_in", 32'(avg_data_in), 0);
        chk("rst_res_valid",   32'(res_valid),   0);
        chk("rst_res_data",    32'(res_data),    0);
        chk("rst_res_id",      32'(res_id),      0);
        chk("rst_res_tmo",     32'(res_tmo),     0);
        chk("rst_busy",        32'(busy),        0);
    endtask

    // Cycle engine: drives requesters per the config arrays and checks FEED behaviour.
    task automatic run(input int budget, input int want_res, input int stop_sent);
        int sent[NREQ], bub[NREQ];
        bit bub_done[NREQ];
        int idle, nres0, tot, g;
        bit prev_gnt, first, pw, in_wait, v;
        for (int k = 0; k < NREQ; k++) begin sent[k] = 0; bub[k] = 0; bub_done[k] = 1'b0; end
        idle = 0; nres0 = nres; tot = 0; g = 0;
        prev_gnt = 1'b0; first = 1'b1; pw = 1'b0;
        act_n = 0; act_first = 0; act_last = 0; wait_start = -1; rv_cyc = -1;
        glog.delete();
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #2; cyc++;
            in_wait = busy && (req_ready == '0) && !res_valid;
            if (in_wait && !pw) wait_start = cyc;
            pw = in_wait;
            if (res_valid && rv_cyc < 0) rv_cyc = cyc;
            for (int k = 0; k < NREQ; k++) begin
                v = (sent[k] < quota[k] * WIN) && (bub[k] == 0);
                req_valid[k] = v;
                req_data[8*k +: 8] = v ? samp(k, sent[k]) : 8'hA5;
            end
            if (res_valid && hold > 0) begin res_ready = 1'b0; hold--; end
            else res_ready = 1'b1;
            if (stray && req_ready != '0 && tot == 1) begin
                man_done = 1'b1; man_data = 8'h77; stray = 1'b0;
            end else begin
                man_done = coin && in_wait && (cyc - wait_start == TMO - 1);
                man_data = 8'hFD;
            end
            #1;
            chk("ready_onehot", 32'($onehot0(req_ready)), 1);
            if (req_ready != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) if (req_ready[k]) g = k;
                if (!prev_gnt) begin
                    glog.push_back(g);
                    if (!first) chk("idle_gap", idle, 1);
                    first = 1'b0;
                end
                if (req_valid[g]) begin
                    chk("active",  32'(avg_active),  1);
                    chk("data_in", 32'(avg_data_in), 32'(samp(g, sent[g])));
                    if (act_n == 0) act_first = cyc;
                    act_last = cyc; act_n++;
                    sent[g]++; tot++;
                    if (bub_len[g] > 0 && !bub_done[g] && sent[g] % WIN == bub_at[g]) begin
                        bub[g] = bub_len[g]; bub_done[g] = 1'b1;
                    end
                end else begin
                    chk("bubble_active",  32'(avg_active),  0);
                    chk("bubble_data_in", 32'(avg_data_in), 0);
                    if (bub[g] > 0) bub[g]--;
                end
                idle = 0;
            end else begin
                chk("idle_active", 32'(avg_active), 0);
                if (!busy) idle++;
            end
            prev_gnt = (req_ready != '0);
            if (stop_sent > 0 && tot >= stop_sent) return;
            if (nres - nres0 >= want_res) return;
        end
        chk("cycle_budget", nres - nres0, want_res);
    endtask

    initial begin
        req_valid = '0; req_data = '0; res_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2 chk_zero();
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

        // contention: 0,1,3 all valid, expect 0,1,3,0
        clr(); quota[0] = 2; quota[1] = 1; quota[3] = 1;
        dbase[0] = 5; dbase[1] = -7; dbase[3] = 100;
        expq.push_back('{8'd5, 2'd0, 1'b0});
        expq.push_back('{8'hF9, 2'd1, 1'b0});
        expq.push_back('{8'd100, 2'd3, 1'b0});
        expq.push_back('{8'd5, 2'd0, 1'b0});
        run(200, 4, 0);
        chk("grant_count", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("grant_0", glog[0], 0); chk("grant_1", glog[1], 1);
            chk("grant_2", glog[2], 3); chk("grant_3", glog[3], 0);
        end

        // single requester 0 (pointer wraps from 1), samples 10..40
        clr(); quota[0] = 1; dbase[0] = 10; dstep[0] = 10;
        expq.push_back('{8'd25, 2'd0, 1'b0});
        run(100, 1, 0);
        chk("single_active_n", act_n, 4);
        chk("single_active_span", act_last - act_first, 3);

        // bubbles on requester 2 plus result backpressure
        clr(); quota[2] = 1; dbase[2] = -20; dstep[2] = 2; bub_at[2] = 2; bub_len[2] = 2; hold = 5;
        expq.push_back('{8'hEF, 2'd2, 1'b0});
        run(100, 1, 0);
        chk("bubble_active_n", act_n, 4);
        chk("bubble_span", act_last - act_first, 5);
        chk("bp_hold", hs_cyc - rv_cyc, 5);

        // timeout on requester 3
        clr(); quota[3] = 1; dbase[3] = 1; model_en = 1'b0;
        expq.push_back('{8'd0, 2'd3, 1'b1});
        run(100, 1, 0);
        chk("tmo_latency", rv_cyc - wait_start, TMO);

        // stray done in FEED, then done coincident with the timeout
        clr(); quota[1] = 1; dbase[1] = 3; stray = 1'b1; coin = 1'b1;
        expq.push_back('{8'hFD, 2'd1, 1'b0});
        run(100, 1, 0);
        man_done = 1'b0; model_en = 1'b1;

        // reset after 2 of 4 samples on requester 2
        clr(); quota[2] = 1; dbase[2] = 9;
        run(50, 1, 2);
        #2 chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1 chk_zero();
        req_valid = '0;
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

        clr(); quota[0] = 1; quota[3] = 1; dbase[0] = -50; dbase[3] = 60;
        expq.push_back('{8'hCE, 2'd0, 1'b0});
        expq.push_back('{8'd60, 2'd3, 1'b0});
        run(200, 2, 0);
        chk("post_rst_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("post_rst_first", glog[0], 0);
            chk("post_rst_second", glog[1], 3);
        end
        repeat (3) @(posedge clk);
        #3 chk("sb_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
